// File: rtl/msg_pkg.sv
// msg_pkg: message table and shared types for the seven-segment message scroller
package msg_pkg;
    localparam int MSG_MAX = 8;
    localparam int BLANK_CODE = 31;
    localparam int LEN_W = $clog2(MSG_MAX + 1);

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [MSG_MAX-1:0][7:0] codes;
    } msg_t;

    function automatic msg_t mk(input int l, input int c0, input int c1, input int c2,
                                input int c3, input int c4, input int c5);
        msg_t m;
        m = '0;
        m.len = LEN_W'(l);
        m.codes[0] = 8'(c0);
        m.codes[1] = 8'(c1);
        m.codes[2] = 8'(c2);
        m.codes[3] = 8'(c3);
        m.codes[4] = 8'(c4);
        m.codes[5] = 8'(c5);
        return m;
    endfunction

    localparam msg_t MSG_TABLE [16] = '{
        6:       mk(4, 16, 14, 18, 20, 0, 0),
        8:       mk(4, 31, 12, 18, 10, 0, 0),
        9:       mk(4, 31, 10, 0, 0, 0, 0),
        10:      mk(4, 31, 5, 24, 11, 0, 0),
        11:      mk(4, 31, 0, 0, 23, 0, 0),
        12:      mk(4, 31, 0, 1, 24, 0, 0),
        13:      mk(4, 23, 14, 5, 23, 0, 0),
        14:      mk(6, 23, 14, 5, 23, 16, 14),
        default: mk(0, 0, 0, 0, 0, 0, 0)
    };
endpackage

// File: rtl/scroll_tick.sv
// scroll_tick: scroll-rate prescaler with freeze and synchronous clear, one-cycle tick out
module scroll_tick #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt;

    assign tick = !hold && cnt == CW'(TICK_DIV - 1);

    // count 0..TICK_DIV-1, frozen while hold, restarted by reset or a message change
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (!hold)
            cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/msg_scroller.sv
// msg_scroller: maps UI state to a static or cyclically scrolling glyph message
module msg_scroller
    import msg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int CODE_W   = 5,
    parameter int MSG_MAX  = 8,
    parameter int GAP      = 2,
    parameter int TICK_DIV = 25_000_000,
    parameter int BLANK    = 31
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3:0]                 state,
    input  logic                       hold,
    output logic [DIGITS*CODE_W-1:0]   out,
    output logic                       scrolling
);
    localparam int IW = $clog2(MSG_MAX + GAP + DIGITS) + 1;
    localparam int PKG_MAX = msg_pkg::MSG_MAX;
    localparam logic [CODE_W-1:0] BLANK_G = CODE_W'(BLANK);

    if (TICK_DIV < 2) begin : g_div_chk
        $error("TICK_DIV must be at least 2");
    end
    if (MSG_MAX > PKG_MAX) begin : g_max_chk
        $error("MSG_MAX exceeds the package table capacity");
    end
    for (genvar s = 0; s < 16; s++) begin : g_tab
        for (genvar k = 0; k < PKG_MAX; k++) begin : g_code
            if (k < int'(MSG_TABLE[s].len) && int'(MSG_TABLE[s].codes[k]) >= (1 << CODE_W)) begin : g_bad
                $error("message table code does not fit CODE_W");
            end
        end
    end

    logic [3:0]               state_q;
    logic [IW-1:0]            p;
    logic [IW-1:0]            len_w;
    logic [IW-1:0]            s_len;
    logic                     changed;
    logic                     scroll;
    logic                     tick;
    logic [DIGITS*CODE_W-1:0] nxt;
    logic [IW-1:0]            raw;
    logic [IW-1:0]            idx;
    logic [CODE_W-1:0]        g;

    assign changed = state != state_q;
    assign len_w   = IW'(MSG_TABLE[state_q].len);
    assign s_len   = len_w + IW'(GAP);
    assign scroll  = len_w > IW'(DIGITS);

    scroll_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (changed),
        .hold (hold),
        .tick (tick)
    );

    // window mux: digit i shows stream position p+i, wrapped once past the stream end
    always_comb begin
        nxt = '0;
        raw = '0;
        idx = '0;
        g = '0;
        for (int i = 0; i < DIGITS; i++) begin
            raw = p + IW'(i);
            idx = (scroll && raw >= s_len) ? raw - s_len : raw;
            g = BLANK_G;
            for (int k = 0; k < PKG_MAX; k++)
                if (idx == IW'(k) && idx < len_w) g = MSG_TABLE[state_q].codes[k][CODE_W-1:0];
            nxt[(DIGITS-1-i)*CODE_W +: CODE_W] = (len_w == '0) ? '0 : g;
        end
    end

    // state latch, position counter and registered outputs; a state change beats a tick
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= '0;
            p         <= '0;
            out       <= '0;
            scrolling <= 1'b0;
        end else begin
            state_q   <= state;
            out       <= nxt;
            scrolling <= scroll;
            if (changed)
                p <= '0;
            else if (tick && scroll)
                p <= (p == s_len - 1'b1) ? '0 : p + 1'b1;
        end
    end
endmodule

// File: tb/tb_msg_scroller.sv
// tb_msg_scroller: table-driven scoreboard bench for msg_scroller with a fast prescaler
module tb_msg_scroller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  state = '0;
    logic        hold = 1'b0;
    logic [19:0] out;
    logic        scrolling;

    int checks = 0;
    int errors = 0;
    logic [20:0] exp_q [$];

    typedef struct {
        logic        r;
        logic        h;
        logic [3:0]  s;
        int          n;
        logic [19:0] eo;
        logic        es;
        string       nm;
    } vec_t;

    vec_t vecs [14];

    msg_scroller #(.TICK_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .state     (state),
        .hold      (hold),
        .out       (out),
        .scrolling (scrolling)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] g4(input int a, input int b, input int c, input int d);
        return {a[4:0], b[4:0], c[4:0], d[4:0]};
    endfunction

    task automatic apply(input logic r, input logic h, input logic [3:0] s, input int n,
                         input logic [19:0] eo, input logic es, input string nm);
        logic [20:0] want;
        rst = r;
        hold = h;
        state = s;
        exp_q.push_back({es, eo});
        repeat (n) @(posedge clk);
        #1;
        want = exp_q.pop_front();
        checks++;
        if ({scrolling, out} !== want) begin
            errors++;
            $display("FAIL %s: got out=%h scrolling=%b, want out=%h scrolling=%b",
                     nm, out, scrolling, want[19:0], want[20]);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 4'd0,  2,  g4(0, 0, 0, 0),      1'b0, "reset"};
        vecs[1]  = '{1'b0, 1'b0, 4'd6,  2,  g4(16, 14, 18, 20),  1'b0, "static6"};
        vecs[2]  = '{1'b0, 1'b0, 4'd6,  12, g4(16, 14, 18, 20),  1'b0, "static6_ticks"};
        vecs[3]  = '{1'b0, 1'b0, 4'd14, 2,  g4(23, 14, 5, 23),   1'b1, "scroll_p0"};
        vecs[4]  = '{1'b0, 1'b0, 4'd14, 4,  g4(14, 5, 23, 16),   1'b1, "scroll_p1"};
        vecs[5]  = '{1'b0, 1'b0, 4'd14, 4,  g4(5, 23, 16, 14),   1'b1, "scroll_p2"};
        vecs[6]  = '{1'b0, 1'b0, 4'd14, 4,  g4(23, 16, 14, 31),  1'b1, "scroll_p3"};
        vecs[7]  = '{1'b0, 1'b0, 4'd14, 4,  g4(16, 14, 31, 31),  1'b1, "scroll_p4"};
        vecs[8]  = '{1'b0, 1'b0, 4'd14, 4,  g4(14, 31, 31, 23),  1'b1, "scroll_p5"};
        vecs[9]  = '{1'b0, 1'b0, 4'd14, 4,  g4(31, 31, 23, 14),  1'b1, "scroll_p6"};
        vecs[10] = '{1'b0, 1'b0, 4'd14, 4,  g4(31, 23, 14, 5),   1'b1, "scroll_p7"};
        vecs[11] = '{1'b0, 1'b0, 4'd14, 4,  g4(23, 14, 5, 23),   1'b1, "scroll_wrap"};
        vecs[12] = '{1'b0, 1'b0, 4'd3,  2,  g4(0, 0, 0, 0),      1'b0, "empty3"};
        vecs[13] = '{1'b0, 1'b0, 4'd9,  2,  g4(31, 10, 0, 0),    1'b0, "static9"};
        for (int i = 0; i < 14; i++)
            apply(vecs[i].r, vecs[i].h, vecs[i].s, vecs[i].n, vecs[i].eo, vecs[i].es, vecs[i].nm);

        // hold freezes the prescaler at count 2; after release the tick comes one cycle later
        apply(0, 0, 14, 2,  g4(23, 14, 5, 23), 1, "hold_start");
        apply(0, 0, 14, 1,  g4(23, 14, 5, 23), 1, "hold_pre");
        apply(0, 1, 14, 40, g4(23, 14, 5, 23), 1, "hold_frozen");
        apply(0, 0, 14, 2,  g4(23, 14, 5, 23), 1, "hold_resume_early");
        apply(0, 0, 14, 1,  g4(14, 5, 23, 16), 1, "hold_resume_step");

        // state change landing in a tick cycle: old window once more, then the new message
        apply(0, 0, 14, 2,  g4(14, 5, 23, 16), 1, "chg_pre");
        apply(0, 0, 13, 1,  g4(14, 5, 23, 16), 1, "chg_tick_old");
        apply(0, 0, 13, 1,  g4(23, 14, 5, 23), 0, "chg_tick_new");

        // hold raised only during the tick cycle delays the step by exactly one cycle
        apply(0, 0, 14, 2,  g4(23, 14, 5, 23), 1, "htick_start");
        apply(0, 0, 14, 2,  g4(23, 14, 5, 23), 1, "htick_pre");
        apply(0, 1, 14, 1,  g4(23, 14, 5, 23), 1, "htick_held");
        apply(0, 0, 14, 1,  g4(23, 14, 5, 23), 1, "htick_late");
        apply(0, 0, 14, 1,  g4(14, 5, 23, 16), 1, "htick_step");

        // reset while at p=5, then recovery to p=0 two cycles after release
        apply(0, 0, 14, 16, g4(14, 31, 31, 23), 1, "rst_at_p5");
        apply(1, 0, 14, 1,  g4(0, 0, 0, 0),     0, "rst_zero");
        apply(0, 0, 14, 1,  g4(0, 0, 0, 0),     0, "rst_rel1");
        apply(0, 0, 14, 1,  g4(23, 14, 5, 23),  1, "rst_rel2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
